seq_mag_comp: RTL and testbench

Parametrised, handshaked, digit-serial magnitude comparator: the multi-cycle successor to the team's fixed-width combinational comparators. Accepts two N-bit operands, scans them MSB-first D bits per cycle and stops early at the first differing digit group. Supports an unsigned or two's-complement mode per transaction. Sits between operand producers (counters, pointer logic) and control FSMs that tolerate multi-cycle latency in exchange for small area at wide N.

---
 rtl/seq_mag_comp.sv | 117 +++++++++++
 tb/tb_seq_mag_comp.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seq_mag_comp.sv
// seq_mag_comp: digit-serial MSB-first magnitude comparator, D bits per cycle, early exit.
// Latency: result after 1+j cycles (j = first differing digit group), N/D cycles when equal.
// Backpressure: in_ready only in IDLE; DONE holds flags until out_ready (GRAY_IN_EN: Gray inputs).
module seq_mag_comp #(
  parameter int N = 8,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         signed_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         aeqb,
  output logic         agtb,
  output logic         altb
);

  localparam int G  = N / D;
  localparam int CW = (G > 1) ? $clog2(G) : 1;

  generate
    if (N < 2 || D < 1 || (N % D) != 0) begin : g_bad_param
      $error("seq_mag_comp: N must be >= 2 and an exact multiple of D");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [N-1:0]  sa, sb;
  logic [CW-1:0] cnt;
  logic [N-1:0]  a_bin, b_bin, a_key, b_key, msb_flip;
  logic [D-1:0]  da, db;

`ifdef GRAY_IN_EN
  // Gray to binary: each binary bit is the XOR of all Gray bits at and above it
  always_comb begin
    a_bin = '0;
    b_bin = '0;
    for (int i = 0; i < N; i++) begin
      a_bin[i] = ^(a >> i);
      b_bin[i] = ^(b >> i);
    end
  end
`else
  assign a_bin = a;
  assign b_bin = b;
`endif

  // Flipping the sign bit maps two's-complement order onto unsigned order
  assign msb_flip = {signed_mode, {(N-1){1'b0}}};
  assign a_key    = a_bin ^ msb_flip;
  assign b_key    = b_bin ^ msb_flip;

  assign da       = sa[N-1 -: D];
  assign db       = sb[N-1 -: D];
  assign in_ready = (state == IDLE);

  // Control FSM with registered result flags and out_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sa        <= '0;
      sb        <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      aeqb      <= 1'b0;
      agtb      <= 1'b0;
      altb      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sa    <= a_key;
            sb    <= b_key;
            cnt   <= CW'(G - 1);
            aeqb  <= 1'b0;
            agtb  <= 1'b0;
            altb  <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          if (da > db) begin
            agtb      <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (da < db) begin
            altb      <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (cnt == '0) begin
            aeqb      <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            sa  <= sa << D;
            sb  <= sb << D;
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mag_comp.sv
// Directed bench for seq_mag_comp: two instances (D=1 and D=4, N=8).
// Checks reset, latency, flags, back-pressure, mid-run reset and optional Gray input.
module tb_seq_mag_comp;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b;
  logic       signed_mode, out_ready;
  logic       iv1, iv4;
  logic       ir1, ov1, eq1, gt1, lt1;
  logic       ir4, ov4, eq4, gt4, lt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_mag_comp #(.N(8), .D(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b),
    .signed_mode(signed_mode), .out_valid(ov1), .out_ready(out_ready),
    .aeqb(eq1), .agtb(gt1), .altb(lt1)
  );

  seq_mag_comp #(.N(8), .D(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a), .b(b),
    .signed_mode(signed_mode), .out_valid(ov4), .out_ready(out_ready),
    .aeqb(eq4), .agtb(gt4), .altb(lt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Encode a binary operand the way the DUT expects it on its inputs
  function automatic logic [7:0] enc(input logic [7:0] v);
`ifdef GRAY_IN_EN
    return v ^ (v >> 1);
`else
    return v;
`endif
  endfunction

  // One full transaction: accept, measure cycles to out_valid, check flags, drain
  task automatic do_cmp(input bit sel, input logic [7:0] av, input logic [7:0] bv,
                        input bit sm, input int exp_lat, input logic [2:0] exp_flags,
                        input string tag);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready"}, sel ? ir4 : ir1, 1);
    a = av; b = bv; signed_mode = sm; out_ready = 1'b0;
    if (sel) iv4 = 1'b1; else iv1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv1 = 1'b0; iv4 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (sel ? ov4 : ov1) begin
        lat = i;
        break;
      end
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " flags"}, sel ? {eq4, gt4, lt4} : {eq1, gt1, lt1}, exp_flags);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " drained"}, sel ? {ov4, ir4} : {ov1, ir1}, 2'b01);
    chk({tag, " held"}, sel ? {eq4, gt4, lt4} : {eq1, gt1, lt1}, exp_flags);
  endtask

  initial begin
    int lat;
    bit seen;
    rst = 1'b1; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b0;
    iv1 = 1'b0; iv4 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset out_valid", {ov1, ov4}, 2'b00);
    chk("reset flags", {eq1, gt1, lt1, eq4, gt4, lt4}, 6'b0);
    chk("reset in_ready", {ir1, ir4}, 2'b11);

    // Equal operands run all 8 digits
    do_cmp(0, enc(8'hA5), enc(8'hA5), 0, 8, 3'b100, "eq_a5");
    // MSB differs: unsigned vs signed interpretation
    do_cmp(0, enc(8'h80), enc(8'h7F), 0, 1, 3'b010, "u80_7f");
    do_cmp(0, enc(8'h80), enc(8'h7F), 1, 1, 3'b001, "s80_7f");
    do_cmp(0, enc(8'h7F), enc(8'hFF), 1, 1, 3'b010, "s7f_ff");
    // Nibble-serial
    do_cmp(1, enc(8'h3C), enc(8'h3D), 0, 2, 3'b001, "d4_3c_3d");
    do_cmp(1, enc(8'h13), enc(8'h23), 0, 1, 3'b001, "d4_13_23");
    do_cmp(1, enc(8'h5A), enc(8'h5A), 0, 2, 3'b100, "d4_eq");

    // Back-pressure: 0x05 vs 0x09 differs at bit 3 -> 5 cycles, A<B
    @(negedge clk);
    a = enc(8'h05); b = enc(8'h09); signed_mode = 1'b0; iv1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv1 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ov1) begin lat = i; break; end
    end
    chk("bp latency", lat, 5);
    a = enc(8'hFF); b = enc(8'h00); iv1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp hold", {ov1, ir1, eq1, gt1, lt1}, 5'b10001);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp release", {ov1, ir1}, 2'b01);
    @(posedge clk);
    @(negedge clk);
    iv1 = 1'b0;
    chk("bp new accept", {ir1, ov1}, 2'b00);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ov1) begin lat = i; break; end
    end
    chk("bp new latency", lat, 1);
    chk("bp new flags", {eq1, gt1, lt1}, 3'b010);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of an equal compare
    a = enc(8'hA5); b = enc(8'hA5); signed_mode = 1'b0; iv1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst out", {ov1, eq1, gt1, lt1}, 4'b0000);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst in_ready", ir1, 1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ov1) seen = 1'b1;
    end
    chk("midrst no result", seen, 0);

`ifdef GRAY_IN_EN
    // Gray 0x0C = bin 0x08, Gray 0x04 = bin 0x07: first mismatch at bit 3
    do_cmp(0, 8'h0C, 8'h04, 0, 5, 3'b010, "gray_0c_04");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
